// File: rtl/passcode_verifier_pkg.sv
// Shared definitions for the passcode verifier and the lock mode controller.
//   - DIGIT_W / NUM_DIGITS : default digit width and passcode length
//   - digit_t / passcode_t : one digit, and a full passcode as a packed array
//   - state_t              : verifier FSM states
//   - lock_mode_t          : top-level lock mode encoding (used by the mode controller)
package passcode_verifier_pkg;

    localparam int DIGIT_W    = 4;
    localparam int NUM_DIGITS = 6;

    typedef logic [DIGIT_W-1:0]        digit_t;
    typedef digit_t [NUM_DIGITS-1:0]   passcode_t;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_EVAL    = 2'd1,
        ST_LOCKOUT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        MODE_SET      = 2'd0,
        MODE_LOCKED   = 2'd1,
        MODE_LOCKOUT  = 2'd2,
        MODE_UNLOCKED = 2'd3
    } lock_mode_t;

endpackage

// File: rtl/passcode_verifier_lockout_timer.sv
// Lockout countdown timer.
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   load : loads LOCKOUT_CYCLES-1 into the counter
//   done : high in the last counted cycle (counter == 1); the owner leaves
//          lockout on the following edge, at which the counter reaches 0
module passcode_verifier_lockout_timer #(
    parameter int LOCKOUT_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic done
);

    localparam int CNT_W = $clog2(LOCKOUT_CYCLES);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LOCKOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= LOAD_VAL;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - CNT_W'(1);
        end
    end

    assign done = (count_reg == CNT_W'(1));

endmodule

// File: rtl/passcode_verifier.sv
// Passcode verifier: stores a new passcode (set mode) or checks an entry
// against the stored one (verify mode), counts consecutive failures and
// enforces a timed lockout.
//   clk, rst        : clock, asynchronous active-high reset
//   set_mode        : 1 = define new passcode, 0 = verify (taken while digit_cnt==0)
//   digit_in        : entered digit, qualified by digit_valid
//   entry_done      : end-of-entry strobe
//   match/fail      : one-cycle verify result pulses
//   set_ok/set_err  : one-cycle set result pulses
//   locked_out      : high during lockout
//   attempts        : consecutive failures, saturating at 3
//   pw_valid        : a passcode has been committed since reset
//   digit_cnt       : digits accepted in the current entry
module passcode_verifier #(
    parameter int NUM_DIGITS     = passcode_verifier_pkg::NUM_DIGITS,
    parameter int DIGIT_W        = passcode_verifier_pkg::DIGIT_W,
    parameter int MAX_ATTEMPTS   = 3,
    parameter int LOCKOUT_CYCLES = 50_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               set_mode,
    input  logic [DIGIT_W-1:0] digit_in,
    input  logic               digit_valid,
    input  logic               entry_done,
    output logic               match,
    output logic               fail,
    output logic               set_ok,
    output logic               set_err,
    output logic               locked_out,
    output logic [1:0]         attempts,
    output logic               pw_valid,
    output logic [2:0]         digit_cnt
);

    import passcode_verifier_pkg::*;

    if (MAX_ATTEMPTS < 1 || MAX_ATTEMPTS > 3) begin : g_bad_max_attempts
        $error("MAX_ATTEMPTS must be in 1..3");
    end
    if (NUM_DIGITS < 1 || NUM_DIGITS > 7) begin : g_bad_num_digits
        $error("NUM_DIGITS must be in 1..7 to fit the 3-bit digit_cnt");
    end
    if (LOCKOUT_CYCLES < 2) begin : g_bad_lockout
        $error("LOCKOUT_CYCLES must be at least 2");
    end

    localparam logic [2:0] FULL_CNT = 3'(NUM_DIGITS);
    localparam logic [1:0] MAX_ATT  = 2'(MAX_ATTEMPTS);

    state_t                              state_reg, state_next;
    logic [2:0]                          cnt_reg, cnt_next;
    logic                                mismatch_reg, mismatch_next;
    logic                                overflow_reg, overflow_next;
    logic                                mode_reg, mode_next;
    logic                                pw_valid_reg, pw_valid_next;
    logic [1:0]                          attempts_reg, attempts_next;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0]  stored_reg, stored_next;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0]  shadow_reg, shadow_next;
    logic                                timer_load, timer_done;
    logic                                eff_mode, entry_complete;

    passcode_verifier_lockout_timer #(
        .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (timer_load),
        .done (timer_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_COLLECT;
            cnt_reg      <= '0;
            mismatch_reg <= 1'b0;
            overflow_reg <= 1'b0;
            mode_reg     <= 1'b0;
            pw_valid_reg <= 1'b0;
            attempts_reg <= '0;
            stored_reg   <= '0;
            shadow_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            mismatch_reg <= mismatch_next;
            overflow_reg <= overflow_next;
            mode_reg     <= mode_next;
            pw_valid_reg <= pw_valid_next;
            attempts_reg <= attempts_next;
            stored_reg   <= stored_next;
            shadow_reg   <= shadow_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        mismatch_next  = mismatch_reg;
        overflow_next  = overflow_reg;
        mode_next      = mode_reg;
        pw_valid_next  = pw_valid_reg;
        attempts_next  = attempts_reg;
        stored_next    = stored_reg;
        shadow_next    = shadow_reg;
        match          = 1'b0;
        fail           = 1'b0;
        set_ok         = 1'b0;
        set_err        = 1'b0;
        locked_out     = 1'b0;
        timer_load     = 1'b0;
        // The mode register tracks set_mode until the first digit lands, so
        // the first digit itself must use the live input.
        eff_mode       = (cnt_reg == 3'd0) ? set_mode : mode_reg;
        entry_complete = (cnt_reg == FULL_CNT) && !overflow_reg;

        case (state_reg)
            ST_COLLECT: begin
                if (cnt_reg == 3'd0) begin
                    mode_next = set_mode;
                end
                if (digit_valid) begin
                    if (cnt_reg < FULL_CNT) begin
                        if (eff_mode) begin
                            shadow_next[cnt_reg] = digit_in;
                        end else if (digit_in != stored_reg[cnt_reg]) begin
                            mismatch_next = 1'b1;
                        end
                        cnt_next = cnt_reg + 3'd1;
                    end else begin
                        overflow_next = 1'b1;
                    end
                end
                if (entry_done) begin
                    state_next = ST_EVAL;
                end
            end

            ST_EVAL: begin
                state_next    = ST_COLLECT;
                cnt_next      = '0;
                mismatch_next = 1'b0;
                overflow_next = 1'b0;
                if (mode_reg) begin
                    if (entry_complete) begin
                        stored_next   = shadow_reg;
                        pw_valid_next = 1'b1;
                        set_ok        = 1'b1;
                        attempts_next = '0;
                    end else begin
                        set_err = 1'b1;
                    end
                end else if (!pw_valid_reg) begin
                    // Nothing to compare against: reject without penalty.
                    fail = 1'b1;
                end else if (entry_complete && !mismatch_reg) begin
                    match         = 1'b1;
                    attempts_next = '0;
                end else begin
                    fail          = 1'b1;
                    attempts_next = (attempts_reg == 2'd3) ? 2'd3 : attempts_reg + 2'd1;
                    if (attempts_next >= MAX_ATT) begin
                        // locked_out rises with the fail pulse; this cycle is
                        // the first of the LOCKOUT_CYCLES locked cycles.
                        state_next = ST_LOCKOUT;
                        locked_out = 1'b1;
                        timer_load = 1'b1;
                    end
                end
            end

            ST_LOCKOUT: begin
                locked_out = 1'b1;
                if (timer_done) begin
                    attempts_next = '0;
                    state_next    = ST_COLLECT;
                end
            end

            default: begin
                state_next = ST_COLLECT;
            end
        endcase
    end

    assign attempts  = attempts_reg;
    assign pw_valid  = pw_valid_reg;
    assign digit_cnt = cnt_reg;

endmodule

// File: tb/tb_passcode_verifier.sv
module tb_passcode_verifier;

    localparam int ND = 6;
    localparam int DW = 4;
    localparam int MA = 3;
    localparam int LC = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          set_mode;
    logic [DW-1:0] digit_in;
    logic          digit_valid;
    logic          entry_done;
    logic          match, fail, set_ok, set_err, locked_out, pw_valid;
    logic [1:0]    attempts;
    logic [2:0]    digit_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state: whole-entry view of the passcode rules.
    int ent[$];
    int model_stored[ND];
    bit model_pw_valid;
    int model_att;
    bit hold_lockout;

    passcode_verifier #(
        .NUM_DIGITS(ND), .DIGIT_W(DW), .MAX_ATTEMPTS(MA), .LOCKOUT_CYCLES(LC)
    ) dut (
        .clk(clk), .rst(rst), .set_mode(set_mode), .digit_in(digit_in),
        .digit_valid(digit_valid), .entry_done(entry_done), .match(match),
        .fail(fail), .set_ok(set_ok), .set_err(set_err), .locked_out(locked_out),
        .attempts(attempts), .pw_valid(pw_valid), .digit_cnt(digit_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < ND; i++) model_stored[i] = 0;
        model_pw_valid = 1'b0;
        model_att      = 0;
    endtask

    task automatic load_seq(input int a0, a1, a2, a3, a4, a5, input int n);
        int tmp[7];
        tmp = '{a0, a1, a2, a3, a4, a5, 9};
        ent.delete();
        for (int i = 0; i < n; i++) ent.push_back(tmp[i]);
    endtask

    // Drives one entry from ent[], predicts the result from the rules and
    // checks the EVAL cycle, then either waits out a lockout or checks the
    // return to idle.
    task automatic do_entry(input bit mode, input bit same_cycle);
        int n;
        bit e_match, e_fail, e_ok, e_err, e_lock, eq;
        int e_att, lock_len, exp_cnt;
        n = ent.size();
        set_mode = mode;
        for (int i = 0; i < n; i++) begin
            digit_in    = 4'(ent[i]);
            digit_valid = 1'b1;
            entry_done  = same_cycle && (i == n - 1);
            step();
            digit_valid = 1'b0;
            entry_done  = 1'b0;
            if (!(same_cycle && i == n - 1)) repeat ($urandom_range(0, 2)) step();
        end
        if (!same_cycle || n == 0) begin
            exp_cnt = (n > ND) ? ND : n;
            checks++;
            if (digit_cnt !== 3'(exp_cnt)) begin
                errors++;
                $display("FAIL digit_cnt: got %0d expected %0d", digit_cnt, exp_cnt);
            end
            entry_done = 1'b1;
            step();
            entry_done = 1'b0;
        end

        {e_match, e_fail, e_ok, e_err, e_lock} = '0;
        e_att = model_att;
        eq = (n == ND);
        for (int i = 0; i < n && i < ND; i++) if (ent[i] != model_stored[i]) eq = 1'b0;
        if (mode) begin
            if (n == ND) begin
                e_ok = 1'b1;
                for (int i = 0; i < ND; i++) model_stored[i] = ent[i];
                model_pw_valid = 1'b1;
                e_att = 0;
            end else begin
                e_err = 1'b1;
            end
        end else if (!model_pw_valid) begin
            e_fail = 1'b1;
        end else if (eq) begin
            e_match = 1'b1;
            e_att   = 0;
        end else begin
            e_fail = 1'b1;
            e_att  = (model_att >= 3) ? 3 : model_att + 1;
            e_lock = (e_att >= MA);
        end

        checks++;
        if ({match, fail, set_ok, set_err, locked_out} !== {e_match, e_fail, e_ok, e_err, e_lock}
            || attempts !== 2'(model_att)) begin
            errors++;
            $display("FAIL eval: mode=%0b n=%0d got m/f/ok/err/lock=%b att=%0d expected %b att=%0d",
                     mode, n, {match, fail, set_ok, set_err, locked_out}, attempts,
                     {e_match, e_fail, e_ok, e_err, e_lock}, model_att);
        end else begin
            $display("entry mode=%0b n=%0d same_cycle=%0b -> m/f/ok/err/lock=%b",
                     mode, n, same_cycle, {match, fail, set_ok, set_err, locked_out});
        end
        model_att = e_att;

        if (e_lock) begin
            if (hold_lockout) return;
            lock_len = 1;
            for (int c = 0; c < 4 * LC; c++) begin
                digit_valid = 1'($urandom_range(0, 1));
                digit_in    = 4'($urandom_range(0, 15));
                entry_done  = 1'($urandom_range(0, 1));
                set_mode    = 1'($urandom_range(0, 1));
                step();
                checks++;
                if ({match, fail, set_ok, set_err} !== 4'b0000) begin
                    errors++;
                    $display("FAIL lockout_pulse: got %b expected 0000", {match, fail, set_ok, set_err});
                end
                if (locked_out !== 1'b1) break;
                lock_len++;
            end
            digit_valid = 1'b0;
            entry_done  = 1'b0;
            set_mode    = 1'b0;
            checks++;
            if (lock_len != LC) begin
                errors++;
                $display("FAIL lockout_len: got %0d expected %0d", lock_len, LC);
            end
            model_att = 0;
            checks++;
            if (attempts !== 2'd0) begin
                errors++;
                $display("FAIL lockout_attempts: got %0d expected 0", attempts);
            end
        end else begin
            step();
            checks++;
            if (digit_cnt !== 3'd0 || attempts !== 2'(model_att) || pw_valid !== model_pw_valid
                || locked_out !== 1'b0) begin
                errors++;
                $display("FAIL post_eval: cnt=%0d att=%0d pwv=%0b lock=%0b expected 0 %0d %0b 0",
                         digit_cnt, attempts, pw_valid, locked_out, model_att, model_pw_valid);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if ({match, fail, set_ok, set_err, locked_out, pw_valid} !== 6'b0
            || attempts !== 2'd0 || digit_cnt !== 3'd0) begin
            errors++;
            $display("FAIL %s: got pulses/lock/pwv=%b att=%0d cnt=%0d expected all zero",
                     tag, {match, fail, set_ok, set_err, locked_out, pw_valid}, attempts, digit_cnt);
        end else begin
            $display("%s: outputs at reset values", tag);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; set_mode = 1'b0; digit_in = '0; digit_valid = 1'b0; entry_done = 1'b0;
        hold_lockout = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("reset_initial");
        step();
        step();
        check_reset_outputs("reset_held");
        #2 rst = 1'b0;
        step();
    endtask

    task automatic test_verify_before_set();
        load_seq(1, 2, 3, 4, 5, 6, 6);
        do_entry(1'b0, 1'b0);
    endtask

    task automatic test_set_verify();
        load_seq(1, 2, 3, 4, 5, 6, 6);
        do_entry(1'b1, 1'b0);
        do_entry(1'b0, 1'b0);
    endtask

    task automatic test_wrong_digit();
        load_seq(1, 2, 3, 4, 5, 7, 6);
        do_entry(1'b0, 1'b0);
        load_seq(1, 2, 3, 4, 5, 6, 6);
        do_entry(1'b0, 1'b0);
    endtask

    task automatic test_length_errors();
        load_seq(1, 2, 3, 4, 5, 6, 5);
        do_entry(1'b0, 1'b0);
        load_seq(1, 2, 3, 4, 5, 6, 7);
        do_entry(1'b0, 1'b0);
        load_seq(9, 9, 9, 9, 9, 0, 5);
        do_entry(1'b1, 1'b0);
        load_seq(1, 2, 3, 4, 5, 6, 6);
        do_entry(1'b0, 1'b0);
    endtask

    task automatic test_same_cycle_done();
        load_seq(1, 2, 3, 4, 5, 6, 6);
        do_entry(1'b0, 1'b1);
    endtask

    task automatic test_lockout();
        for (int k = 0; k < 3; k++) begin
            load_seq(6, 5, 4, 3, 2, 1, 6);
            do_entry(1'b0, 1'b0);
        end
        load_seq(1, 2, 3, 4, 5, 6, 6);
        do_entry(1'b0, 1'b0);
    endtask

    task automatic test_random();
        int r, n;
        bit mode;
        for (int k = 0; k < 30; k++) begin
            mode = ($urandom_range(0, 3) == 0);
            r = $urandom_range(0, 5);
            n = (r == 0) ? 5 : (r == 1) ? 7 : 6;
            ent.delete();
            for (int i = 0; i < n; i++) begin
                if (!mode && i < ND && $urandom_range(0, 3) != 0) ent.push_back(model_stored[i]);
                else ent.push_back($urandom_range(0, 15));
            end
            do_entry(mode, 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_reset_mid_entry();
        load_seq(1, 2, 3, 4, 5, 6, 6);
        do_entry(1'b1, 1'b0);
        set_mode = 1'b0;
        for (int i = 0; i < 3; i++) begin
            digit_in = 4'(i + 1); digit_valid = 1'b1; step();
        end
        digit_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_outputs("reset_mid_entry");
        rst = 1'b0;
        model_reset();
        step();
        load_seq(1, 2, 3, 4, 5, 6, 6);
        do_entry(1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_lockout();
        load_seq(1, 2, 3, 4, 5, 6, 6);
        do_entry(1'b1, 1'b0);
        hold_lockout = 1'b1;
        for (int k = 0; k < 3; k++) begin
            load_seq(0, 0, 0, 0, 0, 0, 6);
            do_entry(1'b0, 1'b0);
        end
        hold_lockout = 1'b0;
        repeat (3) step();
        checks++;
        if (locked_out !== 1'b1) begin
            errors++;
            $display("FAIL mid_lockout: got locked_out=%0b expected 1", locked_out);
        end
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("reset_mid_lockout");
        rst = 1'b0;
        model_reset();
        step();
        load_seq(1, 2, 3, 4, 5, 6, 6);
        do_entry(1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_verify_before_set();
        test_set_verify();
        test_wrong_digit();
        test_length_errors();
        test_same_cycle_done();
        test_lockout();
        test_random();
        test_reset_mid_entry();
        test_reset_mid_lockout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
